// File: rtl/keypad_scan_encoder.sv
// 4x4 active-low keypad scanner: row drive, debounce, lowest-column priority, valid/ready key delivery.
// Optional auto-repeat while a key is held is enabled with `define KEYPAD_REPEAT_EN.
`timescale 1ns/1ps
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_CNT   = 3,
  parameter int REPEAT_SAMPLES = 50
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held
);

  localparam int         DW       = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, cols_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [3:0]      row_d;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      code_d;
  logic            vld_d, held_d;
  logic            sample, cand_pressed;
  logic [3:0]      row_next;

`ifdef KEYPAD_REPEAT_EN
  localparam int          RW       = $clog2(REPEAT_SAMPLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SAMPLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`endif

  function automatic logic [1:0] row_idx(input logic [3:0] rn);
    case (rn)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  endfunction

  // lowest pressed (low) column wins
  function automatic logic [1:0] win_col(input logic [3:0] c);
    casez (c)
      4'b???0: win_col = 2'd0;
      4'b??01: win_col = 2'd1;
      4'b?011: win_col = 2'd2;
      default: win_col = 2'd3;
    endcase
  endfunction

  assign sample       = (dwell_q == DW'(SCAN_DIV - 1));
  assign cand_pressed = ~cols_q[cand_q[1:0]];
  assign row_next     = {row_n[2:0], row_n[3]};
  assign dwell_d      = sample ? '0 : dwell_q + DW'(1);

  always_comb begin
    state_d = state_q;
    row_d   = row_n;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = key_code;
    vld_d   = key_valid;
    held_d  = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
`endif
    case (state_q)
      SCAN: if (sample) begin
        if (cols_q != 4'hF) begin
          cand_d = {row_idx(row_n), win_col(cols_q)};
          cnt_d  = 4'd1;
          if (DEBOUNCE_CNT == 1) begin
            code_d  = {row_idx(row_n), win_col(cols_q)};
            vld_d   = 1'b1;
            state_d = EMIT;
          end else begin
            state_d = DEBOUNCE;
          end
        end else begin
          row_d = row_next;
        end
      end
      DEBOUNCE: if (sample) begin
        if (cand_pressed) begin
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
          if (cnt_q >= DEB_LAST) begin
            code_d  = cand_q;
            vld_d   = 1'b1;
            state_d = EMIT;
          end
        end else begin
          cnt_d   = '0;
          row_d   = row_next;
          state_d = SCAN;
        end
      end
      // a release here is not seen until HOLD; the event is always delivered
      EMIT: if (key_valid && key_ready) begin
        vld_d   = 1'b0;
        held_d  = 1'b1;
        cnt_d   = '0;
        state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
      HOLD: if (sample) begin
        if (!cand_pressed) begin
`ifdef KEYPAD_REPEAT_EN
          rep_d = '0;
`endif
          if (cnt_q >= DEB_LAST) begin
            cnt_d   = '0;
            held_d  = 1'b0;
            row_d   = row_next;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
          if (rep_q >= REP_LAST) begin
            rep_d   = '0;
            vld_d   = 1'b1;
            state_d = EMIT;
          end else begin
            rep_d = rep_q + RW'(1);
          end
`else
          held_d = 1'b1;
`endif
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      sync1_q   <= 4'hF;
      cols_q    <= 4'hF;
      dwell_q   <= '0;
      row_n     <= 4'b1110;
      cand_q    <= '0;
      cnt_q     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= col_n;
      cols_q    <= sync1_q;
      dwell_q   <= dwell_d;
      row_n     <= row_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_code  <= code_d;
      key_valid <= vld_d;
      key_held  <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Scoreboard bench for keypad_scan_encoder: a key-matrix model drives col_n from row_n,
// expected codes are queued per press and a negedge monitor checks every handshake.
`timescale 1ns/1ps
module tb_keypad_scan_encoder;
  localparam int SD = 4, DB = 3, RS = 5;
`ifdef KEYPAD_REPEAT_EN
  localparam int NREP = 4;
`else
  localparam int NREP = 1;
`endif

  logic clk = 1'b0, rst = 1'b1, key_ready = 1'b1;
  logic [3:0] row_n, col_n, key_code;
  logic key_valid, key_held;
  logic [3:0] keys [4];            // keys[r][c] = 1 when key (r,c) is pressed
  int total = 0, passed = 0;
  int exp_q[$];
  logic pv = 1'b0, pr = 1'b0;
  logic [3:0] pc = '0;

  keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB), .REPEAT_SAMPLES(RS)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held));

  always #5 clk = ~clk;

  // passive matrix: a driven (low) row pulls down the columns of its pressed keys
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) if (!row_n[r]) col_n = col_n & ~keys[r];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int exp_code(input int r);
    for (int c = 0; c < 4; c++) if (keys[r][c]) return r * 4 + c;
    return -1;
  endfunction

  function automatic int row_pat(input int r);
    logic [3:0] w;
    w = ~(4'b0001 << r);
    return int'(w);
  endfunction

  task automatic wait_row(input int r);
    int n = 0;
    while (int'(row_n) != row_pat(r) && n < 64) begin tick(); n++; end
    if (n >= 64) chk("row_timeout", int'(row_n), row_pat(r));
  endtask

  // press keys on row r so that they become visible exactly as row r is first driven
  task automatic arm(input int r, input logic [3:0] cols);
    wait_row((r + 3) % 4);
    keys[r] = cols;
    wait_row(r);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!key_valid && n < 60) begin tick(); n++; end
  endtask

  task automatic wait_release();
    int n = 0;
    while (key_held && n < 100) begin tick(); n++; end
    chk("held_fall_timeout", int'(key_held), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pv && !pr) begin
        chk("bp_valid_stable", int'(key_valid), 1);
        chk("bp_code_stable", int'(key_code), int'(pc));
      end
      if (pv && pr) chk("valid_fall_after_accept", int'(key_valid), 0);
      if (key_valid && key_ready) begin
        chk("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("event_code", int'(key_code), exp_q.pop_front());
      end
    end
    pv = key_valid & ~rst;
    pr = key_ready;
    pc = key_code;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    int n, seen;
    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
    repeat (3) tick();
    chk("rst_row_n", int'(row_n), 4'hE);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);
    chk("rst_code", int'(key_code), 0);
    rst = 1'b0;

    // idle scan: each row for SD cycles, row 0..3 then wrap
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      chk("row_sequence", int'(row_n), row_pat((k / SD) % 4));
    end
    repeat (6) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_row_n", int'(row_n), 4'hE);
    chk("async_rst_valid", int'(key_valid), 0);
    chk("async_rst_held", int'(key_held), 0);
    tick(); rst = 1'b0;

    // single press row 2 col 1
    key_ready = 1'b1;
    arm(2, 4'b0010);
    exp_q.push_back(exp_code(2));
    wait_valid(n);
    chk("press_latency", n, 12);
    while (n < 13) begin tick(); n++; end
    chk("held_rise", int'(key_held), 1);
    while (n < 21) begin tick(); n++; end
    keys[2] = 4'h0;
    while (key_held && n < 80) begin tick(); n++; end
    chk("release_latency", n, 32);
    chk("resume_row3", int'(row_n), 4'b0111);

    // bounce: two pressed samples, one released, then re-press off-row
    arm(1, 4'b0010);
    n = 0;
    while (n < 8) begin tick(); n++; end
    keys[1] = 4'h0;
    while (n < 12) begin tick(); n++; end
    chk("bounce_row_advance", int'(row_n), 4'b1011);
    keys[1] = 4'b0010;
    seen = 0;
    while (n < 40) begin
      tick(); n++;
      if (key_valid) seen++;
      if (n == 18) keys[1] = 4'h0;
    end
    chk("bounce_no_event", seen, 0);

    // priority + backpressure, key released while waiting
    key_ready = 1'b0;
    arm(0, 4'b1010);
    exp_q.push_back(exp_code(0));
    wait_valid(n);
    chk("bp_latency", n, 12);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) keys[0] = 4'h0;
    end
    chk("bp_valid_after_wait", int'(key_valid), 1);
    chk("bp_code_after_wait", int'(key_code), 1);
    key_ready = 1'b1;
    tick();
    chk("bp_accept_held", int'(key_held), 1);
    wait_release();
    chk("bp_resume_row1", int'(row_n), 4'b1101);

    // long hold on row 3 col 0: one event, or one per RS samples with auto-repeat
    arm(3, 4'b0001);
    for (int i = 0; i < NREP; i++) exp_q.push_back(exp_code(3));
    seen = 0;
    for (n = 1; n <= 80; n++) begin
      tick();
      if (key_valid) begin
        chk("repeat_timing", n, 12 + RS * SD * seen);
        seen++;
      end
    end
    keys[3] = 4'h0;
    chk("repeat_count", seen, NREP);
    wait_release();

    // reset drops a pending event
    key_ready = 1'b0;
    arm(1, 4'b0100);
    wait_valid(n);
    chk("drop_valid_before_rst", int'(key_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("drop_valid", int'(key_valid), 0);
    chk("drop_held", int'(key_held), 0);
    keys[1] = 4'h0;
    key_ready = 1'b1;
    tick(); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (key_valid) seen++; end
    chk("drop_no_event", seen, 0);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
